// File: rtl/pipeline_spi_pkg.sv
// Shared definitions for the SPI layer controller: opcodes (which double as
// register ids for READ), argument-count table, FSM state encoding and the
// readback value returned for an unknown register id.
package pipeline_spi_pkg;

  localparam logic [7:0] OP_RESET  = 8'h00;
  localparam logic [7:0] OP_MODE   = 8'h01;
  localparam logic [7:0] OP_SCALE  = 8'h03;
  localparam logic [7:0] OP_OFFX   = 8'h04;
  localparam logic [7:0] OP_OFFY   = 8'h05;
  localparam logic [7:0] OP_TRANSP = 8'h06;
  localparam logic [7:0] OP_CLIP_L = 8'h07;
  localparam logic [7:0] OP_CLIP_R = 8'h08;
  localparam logic [7:0] OP_CLIP_T = 8'h09;
  localparam logic [7:0] OP_CLIP_B = 8'h0A;
  localparam logic [7:0] OP_FREEZE = 8'h0B;
  localparam logic [7:0] OP_IMAGE  = 8'h0C;
  localparam logic [7:0] OP_READ   = 8'h0D;
  localparam logic [7:0] OP_ENABLE = 8'h0E;
  localparam logic [7:0] OP_NOP    = 8'hFF;

  localparam logic [15:0] READ_INVALID = 16'hDEAD;

  typedef enum logic [2:0] {
    S_IDLE, S_LAYER, S_ARG, S_COMMIT, S_READ_HI, S_READ_LO, S_IMAGE, S_DISCARD
  } state_e;

  // Argument bytes following the layer byte; 0 marks opcodes with no layer byte
  // (RESET/NOP/IMAGE) as well as unknown opcodes.
  function automatic logic [1:0] arg_count(input logic [7:0] op);
    case (op)
      OP_MODE, OP_SCALE, OP_TRANSP, OP_FREEZE, OP_ENABLE, OP_READ: return 2'd1;
      OP_OFFX, OP_OFFY, OP_CLIP_L, OP_CLIP_R, OP_CLIP_T, OP_CLIP_B: return 2'd2;
      default: return 2'd0;
    endcase
  endfunction

  // Register ids for READ are the write opcodes of the fields.
  function automatic logic reg_id_valid(input logic [7:0] id);
    return (arg_count(id) != 2'd0) && (id != OP_READ);
  endfunction

endpackage

// File: rtl/pipeline_spi_layer_regs.sv
// Field registers of one foreground layer.
//   we/sel/wdata : write field 'sel' (opcode) with the low bits of wdata
//   clr          : reset-command, zero all fields, enable = RESET_ENABLE
//   rd_id/rd_data: combinational readback, offsets sign-extended to 16 bits
//   remaining outputs: the current field values
module pipeline_spi_layer_regs
  import pipeline_spi_pkg::*;
#(
  parameter int   PRECISION              = 11,
  parameter int   TRANSPARENCY_PRECISION = 3,
  parameter logic RESET_ENABLE           = 1'b0
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              we,
  input  logic                              clr,
  input  logic [7:0]                        sel,
  input  logic [15:0]                       wdata,
  input  logic [7:0]                        rd_id,
  output logic                              enable,
  output logic                              freeze,
  output logic [1:0]                        overlay_mode,
  output logic [1:0]                        scale,
  output logic [PRECISION:0]                offset_x,
  output logic [PRECISION:0]                offset_y,
  output logic [PRECISION-1:0]              clip_left,
  output logic [PRECISION-1:0]              clip_right,
  output logic [PRECISION-1:0]              clip_top,
  output logic [PRECISION-1:0]              clip_bottom,
  output logic [TRANSPARENCY_PRECISION-1:0] transparency,
  output logic [15:0]                       rd_data
);

  logic                              enable_q, enable_d, freeze_q, freeze_d;
  logic [1:0]                        mode_q, mode_d, scale_q, scale_d;
  logic [PRECISION:0]                offx_q, offx_d, offy_q, offy_d;
  logic [PRECISION-1:0]              cl_q, cl_d, cr_q, cr_d, ct_q, ct_d, cb_q, cb_d;
  logic [TRANSPARENCY_PRECISION-1:0] tr_q, tr_d;
  logic                              unused_wdata;

  assign unused_wdata = ^wdata[15:PRECISION+1];

  always_comb begin
    enable_d = enable_q; freeze_d = freeze_q; mode_d = mode_q; scale_d = scale_q;
    offx_d = offx_q; offy_d = offy_q; cl_d = cl_q; cr_d = cr_q; ct_d = ct_q; cb_d = cb_q;
    tr_d = tr_q;
    if (clr) begin
      enable_d = RESET_ENABLE; freeze_d = 1'b0; mode_d = '0; scale_d = '0;
      offx_d = '0; offy_d = '0; cl_d = '0; cr_d = '0; ct_d = '0; cb_d = '0; tr_d = '0;
    end else if (we) begin
      case (sel)
        OP_MODE:   mode_d   = wdata[1:0];
        OP_SCALE:  scale_d  = wdata[1:0];
        OP_OFFX:   offx_d   = wdata[PRECISION:0];
        OP_OFFY:   offy_d   = wdata[PRECISION:0];
        OP_TRANSP: tr_d     = wdata[TRANSPARENCY_PRECISION-1:0];
        OP_CLIP_L: cl_d     = wdata[PRECISION-1:0];
        OP_CLIP_R: cr_d     = wdata[PRECISION-1:0];
        OP_CLIP_T: ct_d     = wdata[PRECISION-1:0];
        OP_CLIP_B: cb_d     = wdata[PRECISION-1:0];
        OP_FREEZE: freeze_d = wdata[0];
        OP_ENABLE: enable_d = wdata[0];
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      enable_q <= RESET_ENABLE; freeze_q <= 1'b0; mode_q <= '0; scale_q <= '0;
      offx_q <= '0; offy_q <= '0; cl_q <= '0; cr_q <= '0; ct_q <= '0; cb_q <= '0; tr_q <= '0;
    end else begin
      enable_q <= enable_d; freeze_q <= freeze_d; mode_q <= mode_d; scale_q <= scale_d;
      offx_q <= offx_d; offy_q <= offy_d; cl_q <= cl_d; cr_q <= cr_d; ct_q <= ct_d;
      cb_q <= cb_d; tr_q <= tr_d;
    end
  end

  always_comb begin
    case (rd_id)
      OP_MODE:   rd_data = 16'(mode_q);
      OP_SCALE:  rd_data = 16'(scale_q);
      OP_OFFX:   rd_data = {{(15-PRECISION){offx_q[PRECISION]}}, offx_q};
      OP_OFFY:   rd_data = {{(15-PRECISION){offy_q[PRECISION]}}, offy_q};
      OP_TRANSP: rd_data = 16'(tr_q);
      OP_CLIP_L: rd_data = 16'(cl_q);
      OP_CLIP_R: rd_data = 16'(cr_q);
      OP_CLIP_T: rd_data = 16'(ct_q);
      OP_CLIP_B: rd_data = 16'(cb_q);
      OP_FREEZE: rd_data = 16'(freeze_q);
      OP_ENABLE: rd_data = 16'(enable_q);
      default:   rd_data = READ_INVALID;
    endcase
  end

  assign enable = enable_q;       assign freeze = freeze_q;
  assign overlay_mode = mode_q;   assign scale = scale_q;
  assign offset_x = offx_q;       assign offset_y = offy_q;
  assign clip_left = cl_q;        assign clip_right = cr_q;
  assign clip_top = ct_q;         assign clip_bottom = cb_q;
  assign transparency = tr_q;

endmodule

// File: rtl/pipeline_spi_layer_control.sv
// SPI command decoder and per-layer register bank.
//   spi_active/rx_byte/rx_valid : byte stream from spi_slave
//   tx_byte/tx_load             : readback bytes toward MISO
//   image_mode                  : image-upload handoff flag
//   ctrl_*                      : packed per-layer control fields
//   err_count                   : saturating protocol-error count
// Frames are buffered and only applied in the single COMMIT cycle, so a
// frame cut short by spi_active falling never touches the registers.
module pipeline_spi_layer_control
  import pipeline_spi_pkg::*;
#(
  parameter int PRECISION              = 11,
  parameter int TRANSPARENCY_PRECISION = 3,
  parameter int NUM_LAYERS             = 2,
  parameter int LAYER_BITS             = 3
) (
  input  logic                                         clk,
  input  logic                                         rst,
  input  logic                                         spi_active,
  input  logic [7:0]                                   rx_byte,
  input  logic                                         rx_valid,
  output logic [7:0]                                   tx_byte,
  output logic                                         tx_load,
  output logic                                         image_mode,
  output logic [NUM_LAYERS-1:0]                        ctrl_layer_enable,
  output logic [NUM_LAYERS-1:0]                        ctrl_fg_freeze,
  output logic [2*NUM_LAYERS-1:0]                      ctrl_overlay_mode,
  output logic [2*NUM_LAYERS-1:0]                      ctrl_fg_scale,
  output logic [(PRECISION+1)*NUM_LAYERS-1:0]          ctrl_fg_offset_x,
  output logic [(PRECISION+1)*NUM_LAYERS-1:0]          ctrl_fg_offset_y,
  output logic [PRECISION*NUM_LAYERS-1:0]              ctrl_fg_clip_left,
  output logic [PRECISION*NUM_LAYERS-1:0]              ctrl_fg_clip_right,
  output logic [PRECISION*NUM_LAYERS-1:0]              ctrl_fg_clip_top,
  output logic [PRECISION*NUM_LAYERS-1:0]              ctrl_fg_clip_bottom,
  output logic [TRANSPARENCY_PRECISION*NUM_LAYERS-1:0] ctrl_fg_transparency,
  output logic [7:0]                                   err_count
);

  state_e                state_q, state_d;
  logic [7:0]            op_q, op_d;
  logic [LAYER_BITS-1:0] layer_q, layer_d;
  logic [1:0]            cnt_q, cnt_d;
  logic [15:0]           buf_q, buf_d;
  logic [7:0]            err_q, err_d;
  logic [7:0]            tx_byte_q, tx_byte_d;
  logic                  tx_load_q, tx_load_d;
  logic                  err_inc, commit_we, commit_clr;
  logic [NUM_LAYERS-1:0][15:0] rd_all;
  logic [15:0]           rb;

  // Argument buffer kept separate from the FSM so the readback path (which
  // looks at buf_d to see the reg id on the cycle it arrives) has no loop.
  always_comb begin
    buf_d = buf_q;
    if (rx_valid && state_q == S_LAYER) buf_d = '0;
    else if (rx_valid && state_q == S_ARG) buf_d = {buf_q[7:0], rx_byte};
  end

  always_comb begin
    rb = READ_INVALID;
    for (int i = 0; i < NUM_LAYERS; i++)
      if (layer_q == LAYER_BITS'(i)) rb = rd_all[i];
  end

  always_comb begin
    state_d = state_q; op_d = op_q; layer_d = layer_q; cnt_d = cnt_q;
    tx_byte_d = tx_byte_q; tx_load_d = 1'b0;
    err_inc = 1'b0; commit_we = 1'b0; commit_clr = 1'b0;
    if (!spi_active) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: if (rx_valid) begin
          op_d = rx_byte;
          if (rx_byte == OP_IMAGE) state_d = S_IMAGE;
          else if (rx_byte == OP_RESET || rx_byte == OP_NOP) state_d = S_COMMIT;
          else if (arg_count(rx_byte) != 2'd0) state_d = S_LAYER;
          else begin err_inc = 1'b1; state_d = S_DISCARD; end
        end
        S_LAYER: if (rx_valid) begin
          if (rx_byte >= 8'(NUM_LAYERS)) begin
            err_inc = 1'b1; state_d = S_DISCARD;
          end else begin
            layer_d = rx_byte[LAYER_BITS-1:0];
            cnt_d   = arg_count(op_q);
            state_d = S_ARG;
          end
        end
        S_ARG: if (rx_valid) begin
          cnt_d = cnt_q - 2'd1;
          if (cnt_q == 2'd1) begin
            if (op_q == OP_READ) begin
              // rb already reflects the reg id arriving this cycle
              tx_byte_d = rb[15:8];
              tx_load_d = 1'b1;
              err_inc   = !reg_id_valid(rx_byte);
              state_d   = S_READ_HI;
            end else begin
              state_d = S_COMMIT;
            end
          end
        end
        S_COMMIT: begin
          commit_clr = (op_q == OP_RESET);
          commit_we  = (op_q != OP_RESET) && (op_q != OP_NOP);
          err_inc    = rx_valid;
          state_d    = S_IDLE;
        end
        S_READ_HI: if (rx_valid) begin
          tx_byte_d = rb[7:0];
          tx_load_d = 1'b1;
          state_d   = S_READ_LO;
        end
        S_READ_LO: if (rx_valid) state_d = S_IDLE;
        default: ;  // IMAGE and DISCARD wait for spi_active to fall
      endcase
    end
    err_d = (err_inc && err_q != 8'hFF) ? err_q + 8'd1 : err_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE; op_q <= '0; layer_q <= '0; cnt_q <= '0; buf_q <= '0;
      err_q <= '0; tx_byte_q <= '0; tx_load_q <= 1'b0;
    end else begin
      state_q <= state_d; op_q <= op_d; layer_q <= layer_d; cnt_q <= cnt_d; buf_q <= buf_d;
      err_q <= err_d; tx_byte_q <= tx_byte_d; tx_load_q <= tx_load_d;
    end
  end

  assign tx_byte    = tx_byte_q;
  assign tx_load    = tx_load_q;
  assign err_count  = err_q;
  assign image_mode = (state_q == S_IMAGE);

  for (genvar i = 0; i < NUM_LAYERS; i++) begin : g_layer
    pipeline_spi_layer_regs #(
      .PRECISION(PRECISION),
      .TRANSPARENCY_PRECISION(TRANSPARENCY_PRECISION),
      .RESET_ENABLE((i == 0) ? 1'b1 : 1'b0)
    ) u_regs (
      .clk          (clk),
      .rst          (rst),
      .we           (commit_we && (layer_q == LAYER_BITS'(i))),
      .clr          (commit_clr),
      .sel          (op_q),
      .wdata        (buf_q),
      .rd_id        (buf_d[7:0]),
      .enable       (ctrl_layer_enable[i]),
      .freeze       (ctrl_fg_freeze[i]),
      .overlay_mode (ctrl_overlay_mode[2*i +: 2]),
      .scale        (ctrl_fg_scale[2*i +: 2]),
      .offset_x     (ctrl_fg_offset_x[i*(PRECISION+1) +: PRECISION+1]),
      .offset_y     (ctrl_fg_offset_y[i*(PRECISION+1) +: PRECISION+1]),
      .clip_left    (ctrl_fg_clip_left[i*PRECISION +: PRECISION]),
      .clip_right   (ctrl_fg_clip_right[i*PRECISION +: PRECISION]),
      .clip_top     (ctrl_fg_clip_top[i*PRECISION +: PRECISION]),
      .clip_bottom  (ctrl_fg_clip_bottom[i*PRECISION +: PRECISION]),
      .transparency (ctrl_fg_transparency[i*TRANSPARENCY_PRECISION +: TRANSPARENCY_PRECISION]),
      .rd_data      (rd_all[i])
    );
  end

endmodule

// File: tb/tb_pipeline_spi_layer_control.sv
module tb_pipeline_spi_layer_control;
  import pipeline_spi_pkg::*;

  localparam int P  = 11;
  localparam int TP = 3;
  localparam int NL = 2;

  logic clk = 1'b0, rst = 1'b1, spi_active = 1'b0, rx_valid = 1'b0;
  logic [7:0] rx_byte = '0;
  logic [7:0] tx_byte, err_count;
  logic tx_load, image_mode;
  logic [NL-1:0] ctrl_layer_enable, ctrl_fg_freeze;
  logic [2*NL-1:0] ctrl_overlay_mode, ctrl_fg_scale;
  logic [(P+1)*NL-1:0] ctrl_fg_offset_x, ctrl_fg_offset_y;
  logic [P*NL-1:0] ctrl_fg_clip_left, ctrl_fg_clip_right, ctrl_fg_clip_top, ctrl_fg_clip_bottom;
  logic [TP*NL-1:0] ctrl_fg_transparency;

  int checks = 0, errors = 0;
  logic [7:0] txq[$];
  logic [7:0] exp_err;

  pipeline_spi_layer_control #(.PRECISION(P), .TRANSPARENCY_PRECISION(TP),
                               .NUM_LAYERS(NL), .LAYER_BITS(3)) dut (
    .clk(clk), .rst(rst), .spi_active(spi_active), .rx_byte(rx_byte), .rx_valid(rx_valid),
    .tx_byte(tx_byte), .tx_load(tx_load), .image_mode(image_mode),
    .ctrl_layer_enable(ctrl_layer_enable), .ctrl_fg_freeze(ctrl_fg_freeze),
    .ctrl_overlay_mode(ctrl_overlay_mode), .ctrl_fg_scale(ctrl_fg_scale),
    .ctrl_fg_offset_x(ctrl_fg_offset_x), .ctrl_fg_offset_y(ctrl_fg_offset_y),
    .ctrl_fg_clip_left(ctrl_fg_clip_left), .ctrl_fg_clip_right(ctrl_fg_clip_right),
    .ctrl_fg_clip_top(ctrl_fg_clip_top), .ctrl_fg_clip_bottom(ctrl_fg_clip_bottom),
    .ctrl_fg_transparency(ctrl_fg_transparency), .err_count(err_count));

  always #5 clk = ~clk;

  always @(negedge clk) if (tx_load) txq.push_back(tx_byte);

  initial begin
    #1000000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  typedef struct {
    int          n;      // frame length in bytes, 0 = check only
    logic [31:0] bytes;  // left-aligned, first byte in [31:24]
    logic [7:0]  op;     // field to check
    int          layer;
    logic [15:0] val;
    logic [7:0]  err;
  } vec_t;

  vec_t vecs[17];

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%h want=%h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] fld(input logic [7:0] op, input int l);
    logic [P:0] o;
    case (op)
      OP_MODE:   return 16'(ctrl_overlay_mode[2*l +: 2]);
      OP_SCALE:  return 16'(ctrl_fg_scale[2*l +: 2]);
      OP_OFFX:   begin o = ctrl_fg_offset_x[l*(P+1) +: P+1]; return {{(15-P){o[P]}}, o}; end
      OP_OFFY:   begin o = ctrl_fg_offset_y[l*(P+1) +: P+1]; return {{(15-P){o[P]}}, o}; end
      OP_TRANSP: return 16'(ctrl_fg_transparency[l*TP +: TP]);
      OP_CLIP_L: return 16'(ctrl_fg_clip_left[l*P +: P]);
      OP_CLIP_R: return 16'(ctrl_fg_clip_right[l*P +: P]);
      OP_CLIP_T: return 16'(ctrl_fg_clip_top[l*P +: P]);
      OP_CLIP_B: return 16'(ctrl_fg_clip_bottom[l*P +: P]);
      OP_FREEZE: return 16'(ctrl_fg_freeze[l]);
      OP_ENABLE: return 16'(ctrl_layer_enable[l]);
      default:   return 16'hxxxx;
    endcase
  endfunction

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk); rx_byte = b; rx_valid = 1'b1;
    @(negedge clk); rx_valid = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic frame(input int n, input logic [31:0] bytes);
    @(negedge clk); spi_active = 1'b1;
    for (int k = 0; k < n; k++) send_byte(bytes[8*(3-k) +: 8]);
    @(negedge clk); spi_active = 1'b0;
    @(negedge clk);
  endtask

  task automatic check_reset_state(input string tag);
    chk({tag, "_en"}, 16'(ctrl_layer_enable), 16'h0001);
    chk({tag, "_zero"}, 16'(|{ctrl_fg_freeze, ctrl_overlay_mode, ctrl_fg_scale, ctrl_fg_offset_x,
        ctrl_fg_offset_y, ctrl_fg_clip_left, ctrl_fg_clip_right, ctrl_fg_clip_top,
        ctrl_fg_clip_bottom, ctrl_fg_transparency}), 16'h0000);
    chk({tag, "_tx"}, {7'd0, tx_load, tx_byte}, 16'h0000);
    chk({tag, "_img"}, 16'(image_mode), 16'h0000);
    chk({tag, "_err"}, 16'(err_count), 16'h0000);
  endtask

  task automatic check_read(input string tag, input logic [15:0] exp);
    logic [15:0] got;
    got = (txq.size() == 2) ? {txq[0], txq[1]} : 16'hxxxx;
    chk({tag, "_cnt"}, 16'(txq.size()), 16'd2);
    chk({tag, "_val"}, got, exp);
  endtask

  initial begin
    vecs[0]  = '{4, 32'h04010F38, OP_OFFX,   1, 16'hFF38, 8'd0};
    vecs[1]  = '{0, 32'h0,        OP_OFFX,   0, 16'h0000, 8'd0};
    vecs[2]  = '{4, 32'h07050010, OP_CLIP_L, 1, 16'h0000, 8'd1};
    vecs[3]  = '{3, 32'h01000200, OP_MODE,   0, 16'h0002, 8'd1};
    vecs[4]  = '{3, 32'h0E010100, OP_ENABLE, 1, 16'h0001, 8'd1};
    vecs[5]  = '{4, 32'h0900FFFF, OP_CLIP_T, 0, 16'h07FF, 8'd1};
    vecs[6]  = '{4, 32'h05000005, OP_OFFY,   0, 16'h0005, 8'd1};
    vecs[7]  = '{3, 32'h03010700, OP_SCALE,  1, 16'h0003, 8'd1};
    vecs[8]  = '{3, 32'h06010500, OP_TRANSP, 1, 16'h0005, 8'd1};
    vecs[9]  = '{3, 32'h0B000100, OP_FREEZE, 0, 16'h0001, 8'd1};
    vecs[10] = '{1, 32'h22000000, OP_MODE,   0, 16'h0002, 8'd2};
    vecs[11] = '{1, 32'hFF000000, OP_MODE,   0, 16'h0002, 8'd2};
    vecs[12] = '{4, 32'h0A010123, OP_CLIP_B, 1, 16'h0123, 8'd2};
    vecs[13] = '{1, 32'h00000000, OP_MODE,   0, 16'h0000, 8'd2};
    vecs[14] = '{0, 32'h0,        OP_ENABLE, 0, 16'h0001, 8'd2};
    vecs[15] = '{0, 32'h0,        OP_ENABLE, 1, 16'h0000, 8'd2};
    vecs[16] = '{0, 32'h0,        OP_OFFX,   1, 16'h0000, 8'd2};

    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_reset_state("reset");

    for (int i = 0; i < 17; i++) begin
      if (vecs[i].n > 0) frame(vecs[i].n, vecs[i].bytes);
      chk($sformatf("vec%0d_field", i), fld(vecs[i].op, vecs[i].layer), vecs[i].val);
      chk($sformatf("vec%0d_err", i), 16'(err_count), 16'(vecs[i].err));
    end
    exp_err = 8'd2;

    // Commit latency: new value visible after the second edge, not the first.
    @(negedge clk); spi_active = 1'b1;
    send_byte(OP_CLIP_R); send_byte(8'h00); send_byte(8'h00);
    @(negedge clk); rx_byte = 8'h42; rx_valid = 1'b1;
    @(negedge clk); rx_valid = 1'b0;
    chk("lat_edge1", fld(OP_CLIP_R, 0), 16'h0000);
    @(negedge clk);
    chk("lat_edge2", fld(OP_CLIP_R, 0), 16'h0042);
    @(negedge clk); spi_active = 1'b0; @(negedge clk);

    // Aborted frame leaves the field alone and the next frame starts fresh.
    frame(3, 32'h08000100);
    chk("abort_clip", fld(OP_CLIP_R, 0), 16'h0042);
    frame(3, 32'h01010300);
    chk("abort_next", fld(OP_MODE, 1), 16'h0003);

    // Drop coincident with the final arg byte: nothing written.
    @(negedge clk); spi_active = 1'b1;
    send_byte(OP_CLIP_R); send_byte(8'h00); send_byte(8'h01);
    @(negedge clk); rx_byte = 8'h55; rx_valid = 1'b1; spi_active = 1'b0;
    @(negedge clk); rx_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("dropfinal_clip", fld(OP_CLIP_R, 0), 16'h0042);
    chk("dropfinal_err", 16'(err_count), 16'(exp_err));

    // Readback.
    frame(3, 32'h06010500);
    txq.delete();
    frame(5, 32'h0D0106AA);
    check_read("rd_transp", 16'h0005);
    frame(4, 32'h0400FF38);
    txq.delete();
    frame(4, 32'h0D000411);
    check_read("rd_offx", 16'hFF38);
    txq.delete();
    frame(4, 32'h0D000211);
    exp_err = exp_err + 8'd1;
    check_read("rd_bad", 16'hDEAD);
    chk("rd_bad_err", 16'(err_count), 16'(exp_err));

    // Byte landing in the COMMIT cycle is dropped and counted.
    @(negedge clk); spi_active = 1'b1;
    send_byte(OP_MODE); send_byte(8'h00);
    @(negedge clk); rx_byte = 8'h01; rx_valid = 1'b1;
    @(negedge clk); rx_byte = 8'h00;
    @(negedge clk); rx_valid = 1'b0;
    repeat (2) @(negedge clk);
    exp_err = exp_err + 8'd1;
    chk("collide_mode", fld(OP_MODE, 0), 16'h0001);
    chk("collide_en", 16'(ctrl_layer_enable), 16'h0001);
    chk("collide_err", 16'(err_count), 16'(exp_err));
    @(negedge clk); spi_active = 1'b0; @(negedge clk);

    // Image handoff: payload (including opcode-looking bytes) is ignored.
    begin
      int bad;
      bad = 0;
      @(negedge clk); spi_active = 1'b1;
      send_byte(OP_IMAGE);
      for (int i = 0; i < 100; i++) begin
        @(negedge clk); rx_byte = 8'(i); rx_valid = 1'b1;
        if (image_mode !== 1'b1) bad++;
        @(negedge clk); rx_valid = 1'b0;
      end
      chk("img_flag", 16'(bad), 16'd0);
      chk("img_mode", fld(OP_MODE, 0), 16'h0001);
      chk("img_clip", fld(OP_CLIP_R, 0), 16'h0042);
      chk("img_err", 16'(err_count), 16'(exp_err));
      @(negedge clk); spi_active = 1'b0;
      @(negedge clk);
      chk("img_off", 16'(image_mode), 16'h0000);
    end

    // Error counter saturation.
    for (int i = 0; i < 260; i++) frame(1, 32'h22000000);
    chk("err_sat", 16'(err_count), 16'h00FF);

    // Reset in the middle of an OFFX frame, then decode from IDLE.
    @(negedge clk); spi_active = 1'b1;
    send_byte(OP_OFFX); send_byte(8'h01); send_byte(8'h0F);
    rst = 1'b1;
    @(negedge clk);
    check_reset_state("midrst");
    rst = 1'b0;
    send_byte(OP_MODE); send_byte(8'h01); send_byte(8'h02);
    chk("midrst_next", fld(OP_MODE, 1), 16'h0002);
    chk("midrst_offx", fld(OP_OFFX, 1), 16'h0000);
    @(negedge clk); spi_active = 1'b0; @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipeline_spi_layer_control.md
Name: pipeline_spi_layer_control

Overview:
Byte-level SPI command decoder and register bank driving NUM_LAYERS independent foreground layers. It sits between the spi_slave byte interface and the compositing pipeline. Over the previous single-layer controller it adds per-layer addressing, register readback over MISO, atomic commit (partial commands never apply), and a saturating error counter. Image-upload bytes are handed off through a mode flag and not decoded here.

Parameters:
PRECISION, 11, coordinate width; offsets are PRECISION+1 bits signed
TRANSPARENCY_PRECISION, 3, transparency field width
NUM_LAYERS, 2, foreground layer count (1..8)
LAYER_BITS, 3, width of layer index fields

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-high reset
spi_active  in  1  slave-select asserted (from spi_slave)
rx_byte  in  8  received byte
rx_valid  in  1  one-cycle strobe, rx_byte valid
tx_byte  out  8  next byte for spi_slave to shift out on MISO
tx_load  out  1  one-cycle strobe, tx_byte valid
image_mode  out  1  high after 0x0C until spi_active falls
ctrl_layer_enable  out  NUM_LAYERS  per-layer enable
ctrl_fg_freeze  out  NUM_LAYERS  per-layer freeze
ctrl_overlay_mode  out  2*NUM_LAYERS  packed, layer i at [2i+1:2i]
ctrl_fg_scale  out  2*NUM_LAYERS  packed
ctrl_fg_offset_x / ctrl_fg_offset_y  out  (PRECISION+1)*NUM_LAYERS  packed signed
ctrl_fg_clip_left/right/top/bottom  out  PRECISION*NUM_LAYERS  packed
ctrl_fg_transparency  out  TRANSPARENCY_PRECISION*NUM_LAYERS  packed
err_count  out  8  saturating protocol-error count

Behaviour:
- Reset (async): all ctrl_* = 0, except ctrl_layer_enable = 1 for layer 0 only. tx_byte=0, tx_load=0, image_mode=0, err_count=0, FSM=IDLE.
- Frame: opcode, then layer byte (per-layer opcodes), then args big-endian. Arg counts: MODE 01, SCALE 03, TRANSP 06, FREEZE 0B, ENABLE 0E take 1; OFFX 04, OFFY 05, CLIP 07-0A take 2; RESET 00 and NOP FF take 0 and no layer byte; READ 0D takes layer + 1 reg-id byte.
- States: IDLE, LAYER, ARG, COMMIT, READ_HI, READ_LO, IMAGE, DISCARD.
- IDLE: on rx_valid, latch the opcode. 0C -> IMAGE. 00/FF -> COMMIT. Known per-layer opcode -> LAYER. Unknown opcode -> err_count+1, DISCARD.
- LAYER: a layer byte >= NUM_LAYERS gives err_count+1 and DISCARD. Otherwise latch it; ARG with the byte counter set to the arg count.
- ARG: shift each byte into a 16-bit buffer. On the last byte -> COMMIT, or READ_HI for READ.
- COMMIT: a single cycle. It writes the selected field of the selected layer, truncating the buffer to field width (low bits). RESET zeros every layer's fields, sets layer-0 enable only, and leaves err_count unchanged. Outputs change exactly 2 clk edges after the final rx_valid. -> IDLE.
- READ_HI: tx_byte = readback[15:8], zero-extended (offsets sign-extended to 16), tx_load pulses 1 cycle; wait rx_valid -> READ_LO. Unknown reg id returns 0xDEAD and err_count+1.
- READ_LO: load the low byte and pulse tx_load; on the next rx_valid -> IDLE.
- IMAGE: image_mode=1; rx bytes are ignored here.
- DISCARD: ignore bytes until spi_active falls.
- spi_active low overrides every state: next state IDLE, image_mode=0, no commit of partial data. If spi_active falls in the same cycle as the final arg byte, the drop wins and nothing is written.
- err_count saturates at 0xFF.
- rx_valid in COMMIT is impossible by spi_slave byte spacing (>=8 SPI clocks). A byte arriving there is dropped and counted as an error.

Decomposition:
- Shared package pipeline_spi_pkg: opcode constants, arg-count table, reg-id constants for READ, FSM state encodings, READ_INVALID=16'hDEAD.
- One sub-module, pipeline_spi_layer_regs: one instance per layer via generate. It holds the field registers with write-enable, field select, 16-bit data and a readback mux. The top holds the FSM, error counter and tx path.

Test Plan:
- Reset mid-frame: rst during ARG of OFFX -> all outputs at reset values, ctrl_layer_enable=...01, FSM IDLE.
- Write 04,01,0F,38 (NUM_LAYERS=2) -> ctrl_fg_offset_x layer1 = 12'hF38 (-200) 2 cycles after last byte; layer0 unchanged.
- Write 07,05,00,10 with NUM_LAYERS=2 -> no field changes, err_count=1, subsequent bytes ignored until spi_active low; next frame 01,00,02 -> layer0 mode=2.
- Abort: 08,00,01 then spi_active drop -> clip_right unchanged, next frame decodes from IDLE.
- Readback: 06,01,05 then 0D,01,06,xx,xx -> tx_load pulses with 0x00 then 0x05.
- Image handoff: 0C then 100 bytes -> image_mode=1 throughout, no ctrl change; spi_active low -> image_mode=0 next cycle.
